// File: rtl/rx_frame_deserialiser.sv
// Rx frame deserialiser: turns the LSB-first bit stream from the Miller decoder into bytes.
// Each full byte is followed by an odd parity bit. Trailing partial bytes (short frames,
// anticollision) are emitted with their bit count at end of frame.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_soc / in_eoc       start / end of comms strobes from the decoder
//   in_data, in_data_valid  received bit and its strobe
//   in_error              decoder sequence error strobe
//   out_soc / out_eoc     frame start / end strobes
//   out_data, out_data_bits, out_data_valid  byte, valid bit count (0 = 8), byte strobe
//   out_error             frame error, qualified by out_eoc
module rx_frame_deserialiser #(
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_soc,
  input  logic       in_eoc,
  input  logic       in_data,
  input  logic       in_data_valid,
  input  logic       in_error,
  output logic       out_soc,
  output logic       out_eoc,
  output logic [7:0] out_data,
  output logic [2:0] out_data_bits,
  output logic       out_data_valid,
  output logic       out_error
);

  localparam int unsigned ByteCntW = $clog2(MAX_BYTES + 1);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e              state_q, state_d;
  logic [7:0]          shift_q, shift_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [ByteCntW-1:0] byte_cnt_q, byte_cnt_d;
  logic                err_q, err_d;

  logic       out_soc_q, out_soc_d;
  logic       out_eoc_q, out_eoc_d;
  logic       out_valid_q, out_valid_d;
  logic       out_error_q, out_error_d;
  logic [7:0] out_data_q, out_data_d;
  logic [2:0] out_bits_q, out_bits_d;

  logic       parity_ok;
  logic       byte_full;
  logic [7:0] partial;

  // Odd parity: data ones plus the parity bit must give an odd total.
  assign parity_ok = ^{shift_q, in_data};
  assign byte_full = (byte_cnt_q == ByteCntW'(MAX_BYTES));

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    err_d       = err_q;
    out_soc_d   = 1'b0;
    out_eoc_d   = 1'b0;
    out_valid_d = 1'b0;
    out_error_d = 1'b0;
    out_data_d  = out_data_q;
    out_bits_d  = out_bits_q;
    partial     = '0;

    if (in_soc) begin
      // Start from idle, or abandon the current frame without flushing it.
      state_d    = StRecv;
      shift_d    = '0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      err_d      = 1'b0;
      out_soc_d  = 1'b1;
    end else if (state_q == StRecv) begin
      if (in_error) begin
        // A bit arriving in the same cycle is dropped.
        err_d = 1'b1;
      end else if (in_data_valid && !err_q) begin
        if (bit_cnt_q != 4'd8) begin
          shift_d[bit_cnt_q[2:0]] = in_data;
          bit_cnt_d               = bit_cnt_q + 4'd1;
        end else begin
          bit_cnt_d = '0;
          shift_d   = '0;
          if (parity_ok && !byte_full) begin
            out_valid_d = 1'b1;
            out_data_d  = shift_q;
            out_bits_d  = 3'd0;
            byte_cnt_d  = byte_cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      // End of frame sees the bit processed in the same cycle.
      if (in_eoc) begin
        for (int i = 0; i < 8; i++) begin
          partial[i] = (4'(i) < bit_cnt_d) & shift_d[i];
        end
        if (!err_d && (bit_cnt_d != 4'd0) && (bit_cnt_d != 4'd8)) begin
          out_valid_d = 1'b1;
          out_data_d  = partial;
          out_bits_d  = bit_cnt_d[2:0];
        end
        out_eoc_d   = 1'b1;
        out_error_d = err_d | (bit_cnt_d == 4'd8);
        state_d     = StIdle;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      err_q       <= 1'b0;
      out_soc_q   <= 1'b0;
      out_eoc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_error_q <= 1'b0;
      out_data_q  <= '0;
      out_bits_q  <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      err_q       <= err_d;
      out_soc_q   <= out_soc_d;
      out_eoc_q   <= out_eoc_d;
      out_valid_q <= out_valid_d;
      out_error_q <= out_error_d;
      out_data_q  <= out_data_d;
      out_bits_q  <= out_bits_d;
    end
  end

  assign out_soc        = out_soc_q;
  assign out_eoc        = out_eoc_q;
  assign out_data_valid = out_valid_q;
  assign out_error      = out_error_q;
  assign out_data       = out_data_q;
  assign out_data_bits  = out_bits_q;

endmodule

// File: tb/tb_rx_frame_deserialiser.sv
// Bench for rx_frame_deserialiser: two instances (MAX_BYTES 64 and 4) share one input stream
// and are compared every cycle against a queue-based frame model.
module tb_rx_frame_deserialiser;

  logic clk = 1'b0;
  logic rst;
  logic in_soc, in_eoc, in_data, in_data_valid, in_error;

  logic       o_soc[2];
  logic       o_eoc[2];
  logic       o_dv[2];
  logic       o_err[2];
  logic [7:0] o_data[2];
  logic [2:0] o_bits[2];

  always #5 clk = ~clk;

  rx_frame_deserialiser #(.MAX_BYTES(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_soc(in_soc), .in_eoc(in_eoc), .in_data(in_data),
    .in_data_valid(in_data_valid), .in_error(in_error), .out_soc(o_soc[0]),
    .out_eoc(o_eoc[0]), .out_data(o_data[0]), .out_data_bits(o_bits[0]),
    .out_data_valid(o_dv[0]), .out_error(o_err[0])
  );

  rx_frame_deserialiser #(.MAX_BYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_soc(in_soc), .in_eoc(in_eoc), .in_data(in_data),
    .in_data_valid(in_data_valid), .in_error(in_error), .out_soc(o_soc[1]),
    .out_eoc(o_eoc[1]), .out_data(o_data[1]), .out_data_bits(o_bits[1]),
    .out_data_valid(o_dv[1]), .out_error(o_err[1])
  );

  int n_vec = 0;
  int n_bad = 0;
  int max_b[2] = '{64, 4};

  // Model state: received bits of the current byte, global error, per-instance overflow.
  bit mq[$];
  bit m_active;
  bit m_gerr;
  bit m_ovf[2];
  int m_nbytes[2];

  bit         e_soc, e_eoc;
  bit         e_dv[2];
  bit         e_err[2];
  logic [7:0] e_data[2];
  logic [2:0] e_bits[2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void emit(int k, logic [7:0] v, logic [2:0] nb);
    e_dv[k]   = 1'b1;
    e_data[k] = v;
    e_bits[k] = nb;
  endfunction

  function automatic void model_reset();
    m_active = 1'b0;
    mq.delete();
    e_soc = 1'b0;
    e_eoc = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e_dv[k] = 1'b0; e_err[k] = 1'b0; e_data[k] = 8'h00; e_bits[k] = 3'd0;
    end
  endfunction

  function automatic void model_step(bit soc, bit eoc, bit d, bit dv, bit er);
    e_soc = 1'b0;
    e_eoc = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e_dv[k] = 1'b0; e_err[k] = 1'b0;
    end
    if (soc) begin
      m_active = 1'b1;
      mq.delete();
      m_gerr = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_ovf[k] = 1'b0; m_nbytes[k] = 0;
      end
      e_soc = 1'b1;
      return;
    end
    if (!m_active) return;
    if (er) begin
      m_gerr = 1'b1;
    end else if (dv && !m_gerr) begin
      mq.push_back(d);
      if (mq.size() == 9) begin
        int ones = 0;
        logic [7:0] v;
        for (int i = 0; i < 9; i++) ones += int'(mq[i]);
        for (int i = 0; i < 8; i++) v[i] = mq[i];
        if (ones % 2 == 0) begin
          m_gerr = 1'b1;
        end else begin
          for (int k = 0; k < 2; k++) begin
            if (!m_ovf[k]) begin
              if (m_nbytes[k] < max_b[k]) begin
                emit(k, v, 3'd0);
                m_nbytes[k]++;
              end else begin
                m_ovf[k] = 1'b1;
              end
            end
          end
        end
        mq.delete();
      end
    end
    if (eoc) begin
      for (int k = 0; k < 2; k++) begin
        bit ek;
        ek = m_gerr | m_ovf[k];
        if (!ek && mq.size() >= 1 && mq.size() <= 7) begin
          logic [7:0] v;
          v = 8'h00;
          for (int i = 0; i < mq.size(); i++) v[i] = mq[i];
          emit(k, v, 3'(mq.size()));
        end
        e_err[k] = ek | (mq.size() == 8);
      end
      e_eoc    = 1'b1;
      m_active = 1'b0;
    end
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("soc%0d", k), 32'(o_soc[k]), 32'(e_soc));
      check($sformatf("eoc%0d", k), 32'(o_eoc[k]), 32'(e_eoc));
      check($sformatf("valid%0d", k), 32'(o_dv[k]), 32'(e_dv[k]));
      check($sformatf("data%0d", k), 32'(o_data[k]), 32'(e_data[k]));
      check($sformatf("bits%0d", k), 32'(o_bits[k]), 32'(e_bits[k]));
      if (e_eoc) check($sformatf("error%0d", k), 32'(o_err[k]), 32'(e_err[k]));
    end
  endtask

  // Drive one cycle of inputs at a negedge, then check the registered result one cycle later.
  task automatic cyc(input bit soc, input bit eoc, input bit d, input bit dv, input bit er);
    in_soc = soc; in_eoc = eoc; in_data = d; in_data_valid = dv; in_error = er;
    model_step(soc, eoc, d, dv, er);
    @(negedge clk);
    in_soc = 1'b0; in_eoc = 1'b0; in_data = 1'b0; in_data_valid = 1'b0; in_error = 1'b0;
    compare_all();
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, v[i], 1'b1, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit par);
    send_bits(v, 8);
    cyc(1'b0, 1'b0, par, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_soc = 1'b0; in_eoc = 1'b0; in_data = 1'b0; in_data_valid = 1'b0; in_error = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cur;
    int         pos;
    int         n;
    bit         b;
    bit         aborted;
    rst = 1'b1;
    in_soc = 1'b0; in_eoc = 1'b0; in_data = 1'b0; in_data_valid = 1'b0; in_error = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;
    cyc(0, 0, 1, 1, 1);  // ignored while idle

    // REQA short frame
    cyc(1, 0, 0, 0, 0);
    check("reqa_soc", 32'(o_soc[0]), 32'd1);
    send_bits(8'h26, 7);
    cyc(0, 1, 0, 0, 0);
    check("reqa_data", 32'(o_data[0]), 32'h26);
    check("reqa_bits", 32'(o_bits[0]), 32'd7);
    check("reqa_valid", 32'(o_dv[0] & o_eoc[0]), 32'd1);
    check("reqa_err", 32'(o_err[0]), 32'd0);

    // Two full bytes
    cyc(1, 0, 0, 0, 0);
    send_byte(8'h93, 1'b1);
    check("b1_data", 32'(o_data[0]), 32'h93);
    check("b1_valid", 32'(o_dv[0]), 32'd1);
    send_byte(8'h20, 1'b0);
    check("b2_data", 32'(o_data[0]), 32'h20);
    cyc(0, 1, 0, 0, 0);
    check("b2_err", 32'(o_err[0]), 32'd0);

    // Parity error
    cyc(1, 0, 0, 0, 0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h20, 1'b0);
    cyc(0, 1, 0, 0, 0);
    check("par_err", 32'(o_err[0]), 32'd1);

    // Missing parity
    cyc(1, 0, 0, 0, 0);
    send_bits(8'h55, 8);
    cyc(0, 1, 0, 0, 0);
    check("nopar_err", 32'(o_err[0]), 32'd1);

    // Decoder error after 3 bits
    cyc(1, 0, 0, 0, 0);
    send_bits(8'h07, 3);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    check("decerr_err", 32'(o_err[0]), 32'd1);

    // Bit and eoc together on the 5th bit
    cyc(1, 0, 0, 0, 0);
    send_bits(8'hFD, 4);
    cyc(0, 1, 1, 1, 0);
    check("dveoc_bits", 32'(o_bits[0]), 32'd5);
    check("dveoc_data", 32'(o_data[0]), 32'h1D);

    // Overflow on the MAX_BYTES=4 instance
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1), ~^8'(i + 1));
    cyc(0, 1, 0, 0, 0);
    check("ovf_err4", 32'(o_err[1]), 32'd1);
    check("ovf_err64", 32'(o_err[0]), 32'd0);

    // Restart mid-frame
    cyc(1, 0, 0, 0, 0);
    send_bits(8'hFF, 8);
    send_bits(8'h03, 2);
    cyc(1, 0, 0, 0, 0);
    check("restart_soc", 32'(o_soc[0]), 32'd1);
    send_byte(8'hA5, 1'b1);
    check("restart_data", 32'(o_data[0]), 32'hA5);
    cyc(0, 1, 0, 0, 0);

    // Reset mid-frame, then bits before soc are ignored
    cyc(1, 0, 0, 0, 0);
    send_bits(8'h0F, 4);
    do_reset();
    check("rst_data", 32'(o_data[0]), 32'h00);
    send_bits(8'hFF, 8);
    cyc(0, 1, 0, 0, 0);

    // Random regression
    for (int f = 0; f < 1000; f++) begin
      if ($urandom_range(0, 3) == 0) cyc(0, $urandom_range(0, 1), 1, 1, $urandom_range(0, 1));
      cyc(1, 0, 0, 0, 0);
      n = $urandom_range(1, 80);
      pos = 0;
      cur = 8'h00;
      aborted = 1'b0;
      for (int i = 0; i < n && !aborted; i++) begin
        int r;
        if (pos < 8) begin
          b = 1'($urandom);
          cur[pos] = b;
        end else begin
          b = (~^cur) ^ ($urandom_range(0, 39) == 0);
        end
        pos = (pos + 1) % 9;
        if ($urandom_range(0, 9) == 0) cyc(0, 0, 0, 0, 0);
        r = $urandom_range(0, 999);
        if (r < 5) begin
          cyc(0, 0, b, 1, 1);
        end else if (r < 8) begin
          cyc(1, 0, 0, 0, 0);
          pos = 0;
        end else if (r < 10) begin
          do_reset();
          aborted = 1'b1;
        end else if (i == n - 1 && $urandom_range(0, 3) == 0) begin
          cyc(0, 1, b, 1, 0);
          aborted = 1'b1;
        end else begin
          cyc(0, 0, b, 1, 0);
        end
      end
      if (!aborted) cyc(0, 1, 0, 0, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_deserialiser.md
# rx_frame_deserialiser

Converts the bit-level Rx stream from `iso14443_2a` (the ISO/IEC 14443-2A Miller decoder) into bytes for the ISO/IEC 14443-3A layer. The input bits arrive LSB first, and each full byte is followed by its odd parity bit. The block checks parity and reports trailing partial bytes, which covers short frames and anticollision bit-oriented frames. It also frames each packet with start/end strobes and a single error flag. It sits directly downstream of `iso14443_2a` Rx and upstream of the -3A frame handler.

## Interface
Parameters:
- `MAX_BYTES`, default 64: maximum number of full bytes per frame. One more full byte is an overflow error.

Ports:
- `clk`  in  1  system clock; the only clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `in_soc`  in  1  one-cycle start-of-comms strobe from the decoder.
- `in_eoc`  in  1  one-cycle end-of-comms strobe.
- `in_data`  in  1  received bit; valid only when `in_data_valid` is high.
- `in_data_valid`  in  1  one-cycle bit strobe.
- `in_error`  in  1  one-cycle decoder error strobe (sequence error).
- `out_soc`  out  1  one-cycle frame start strobe.
- `out_eoc`  out  1  one-cycle frame end strobe.
- `out_data`  out  8  byte, LSB = first received bit; valid while `out_data_valid` is high.
- `out_data_bits`  out  3  number of valid bits in `out_data`; 0 means 8 (a full byte).
- `out_data_valid`  out  1  one-cycle byte strobe.
- `out_error`  out  1  frame error; meaningful only in the cycle `out_eoc` is high.

## Operation
- The FSM has two states, IDLE and RECV.
- IDLE:
  - Ignores `in_data_valid`, `in_eoc` and `in_error`.
  - On `in_soc`: go to RECV, clear the shift register, `bit_cnt` (0..8), `byte_cnt` and the `err` flag, and pulse `out_soc`.
- RECV, on `in_data_valid` with `err` clear:
  - `bit_cnt` < 8: shift `in_data` into bit position `bit_cnt` and increment `bit_cnt`.
  - `bit_cnt` == 8: the bit is parity.
    - Popcount(data) + parity odd: pulse `out_data_valid` with the byte and `out_data_bits`=0, then increment `byte_cnt`.
    - Otherwise set `err`; nothing is emitted.
    - In both cases `bit_cnt` returns to 0.
  - A completed byte when `byte_cnt` == `MAX_BYTES` sets `err` and is not emitted.
- RECV, on `in_error`: set `err`. Once `err` is set, all further bits are ignored until end of frame.
- RECV, on `in_eoc`:
  - `err` clear and `bit_cnt` in 1..7: pulse `out_data_valid` with the partial byte, `out_data_bits`=`bit_cnt`, and the unused upper bits of `out_data` forced to 0.
  - `bit_cnt` == 8 (full byte with parity missing): set the frame error; the byte is not emitted.
  - `bit_cnt` == 0: no data output.
  - Pulse `out_eoc`, with `out_error` = `err` OR the missing-parity condition, then return to IDLE.
- Simultaneous events in RECV:
  - `in_data_valid` with `in_eoc`: the bit is processed first, then the eoc rules apply to the updated `bit_cnt`.
  - `in_error` with `in_data_valid`: the bit is dropped and `err` is set.
  - `in_error` with `in_eoc`: the frame ends with `out_error`=1.
- `in_soc` while in RECV: the current frame is abandoned with no `out_eoc` and no flush. The block restarts as for IDLE and pulses `out_soc`.
- Per cycle, `out_data_valid` and `out_eoc` may both be high (partial byte plus end). `out_soc` is never high together with either of them.

## Timing
- All outputs are registered.
- Every output strobe follows its causing input strobe by exactly 1 clock.
- `out_data` and `out_data_bits` hold their value until the next `out_data_valid`.
- Reset values: FSM=IDLE, all counters 0, `err`=0.
  - Outputs: `out_soc`=0, `out_eoc`=0, `out_data_valid`=0, `out_error`=0, `out_data`=8'h00, `out_data_bits`=3'd0.
- Asserting `rst` mid-frame clears the state immediately, with no `out_eoc`. After reset release, bits are ignored until the next `in_soc`.
- The block has no backpressure. Input strobes may arrive on consecutive cycles, and every one must be processed.

## Test plan
- REQA short frame: soc, 7 bits of 0x26, eoc -> `out_soc`; then `out_data`=0x26, `out_data_bits`=7, valid and `out_eoc` in the same cycle, `out_error`=0.
- Two full bytes: 0x93 with parity 1, then 0x20 with parity 0, then eoc -> two valid pulses (0x93, then 0x20, both `out_data_bits`=0), then `out_eoc` with `out_error`=0. Each strobe appears 1 cycle after its input.
- Parity error: 0x93 with parity 0, then 0x20 with parity 0, then eoc -> no `out_data_valid` at all, `out_eoc` with `out_error`=1.
- Edge events:
  - 8 bits 0x55 then eoc -> no data, `out_error`=1.
  - `in_error` after 3 bits -> no data, `out_error`=1.
  - `in_data_valid` and `in_eoc` together on the 5th bit -> partial byte emitted with `out_data_bits`=5.
- Overflow: with `MAX_BYTES`=4, send 5 correct bytes -> exactly 4 valid pulses, then `out_eoc` with `out_error`=1.
- Restart and reset:
  - `in_soc` after 10 bits of a frame, then a clean 1-byte frame -> a second `out_soc` and one byte, with no stale bits.
  - `rst` after 4 bits -> all outputs 0. Bits arriving before the next soc are ignored.
- Random regression: 1000 frames of 1..80 bits with correct parity and random error injection -> output matches the scoreboard model. Every soc is paired with exactly one eoc, except where a restart or reset was applied.
